nrisk_ctrl_fsm: RTL and testbench
=================================

Name: nrisk_ctrl_fsm

Overview:
- Multi-cycle control unit for the nRisk core; next generation of the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Uses valid/ack handshakes to instruction and data memory, with a parametrised memory-wait timeout and a retired-instruction counter.
- Keeps the established control-word decode; only the timing of strobes changes.

Parameters:
- OPCODE_W, 4, instruction opcode width (>=4); decode uses opcode[OPCODE_W-1 -: 4], and the remaining low bits are ignored.
- TIMEOUT, 16, maximum cycles spent waiting on a memory ack before entering FAULT (>=1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows leaving IDLE and starting the next fetch.
- imem_ack  in  1  instruction memory has valid data this cycle.
- instr_op  in  OPCODE_W  opcode field of the fetched instruction, sampled when imem_ack=1.
- dmem_ack  in  1  data memory access complete.
- zero_flag  in  1  ALU zero flag, sampled in EXECUTE.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  one-cycle pulse latching the instruction register.
- dmem_req  out  1  data memory request.
- Memoria  out  1  data write strobe, valid only while dmem_req=1.
- J, Br  out  1  jump/branch class, decoded-IR level.
- pc_load  out  1  one-cycle pulse in EXECUTE: J, or Br with zero_flag=1.
- pc_inc  out  1  one-cycle pulse in WRITEBACK when pc_load was not taken.
- Tr  out  1  register-file write enable, WRITEBACK only.
- Sr, MuxAdd, MuxReg2, MuxSaidaJ, MuxSaidaUla  out  1  datapath selects, decoded-IR level.
- ULA  out  2  ALU operation.
- fault  out  1  sticky memory-timeout error.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Decode is combinational from registered IR bits b7..b4 (opcode MSB first):
  - J = b7&~b6&~b5
  - Br = b7&b6&b5
  - MuxAdd = ~b7&~b6&~b5&~b4
  - MuxReg2 = (b7&b6 | ~b7&~b6)&b5
  - ULA[1] = b6&b5
  - ULA[0] = ~b7&(b6^b5) | b7
  - MuxSaidaJ = b7&b6&~b5
  - MuxSaidaUla = ~b7&~b6 | b6&b5
  - Sr = ~b7&~b6&~b5&~b4 | b7&~b6&b5 | ~b7&b6&~b5
  - Tr_dec = ~b7&~b6&~b5&b4 | ~b7&~b6&b5 | b7&~b6&b5 | ~b7&b6&~b5 | b7&b6&b5
  - mem_op = ~b7&b6&~b5; Memoria = mem_op gated by dmem_req.
- Reset (async): state=IDLE, IR=0, retired=0, wait counter=0, all strobes (imem_req, ir_write, dmem_req, pc_load, pc_inc, Tr, fault) = 0. Decoded levels then follow IR=0 (MuxAdd=1, Sr=1).
- States and transitions:
  - IDLE: go to FETCH when enable=1.
  - FETCH: imem_req=1 and held until imem_ack. On ack, IR<=instr_op, ir_write=1 for that cycle, then go to DECODE.
  - DECODE: 1 cycle, no strobes; then EXECUTE.
  - EXECUTE: 1 cycle; pc_load asserted per its rule. Next state is MEMORY if mem_op, else WRITEBACK.
  - MEMORY: dmem_req=1 and held until dmem_ack; Memoria=1 while waiting. On ack, go to WRITEBACK.
  - WRITEBACK: 1 cycle; Tr=Tr_dec, pc_inc = ~(branch taken in EXECUTE), retired += 1 (wraps modulo 2^CNT_W). Next is FETCH if enable=1, else IDLE.
  - FAULT: all strobes 0, fault=1. Exit only via reset.
- Latency: a non-memory instruction takes 4 cycles with zero-wait fetch (ack in the first FETCH cycle). A memory instruction takes 5 + data wait cycles.
- Timeout: the wait counter clears on entry to FETCH/MEMORY and increments each cycle the req is held without ack. Reaching TIMEOUT without ack goes to FAULT; an ack in the same cycle the count hits TIMEOUT wins.
- An ack arriving while no req is asserted is ignored.
- Deasserting enable mid-instruction does not abort; the instruction completes and the FSM then parks in IDLE.
- Reset mid-operation aborts immediately: the req drops the same instant, with no partial Tr/pc pulse.

Test Plan:
- Reset, enable=1, instr_op=4'b0011 with immediate imem_ack -> ir_write pulse at cycle 1, Tr=1 and pc_inc=1 in WRITEBACK at cycle 4, retired=1, ULA=2'b01, MuxReg2=1.
- instr_op=4'b1110, zero_flag=1 -> pc_load=1 in EXECUTE, pc_inc=0 in WRITEBACK, Tr=1, ULA=2'b11; repeat with zero_flag=0 -> pc_load=0, pc_inc=1.
- instr_op=4'b0100, dmem_ack delayed 3 cycles -> dmem_req and Memoria high exactly 4 cycles, then WRITEBACK with Tr=1; total 8 cycles.
- TIMEOUT=4, imem_ack never asserted -> fault=1 after 4 waiting cycles, imem_req=0; fault stays 1 until reset pulse clears it to IDLE.
- enable dropped during EXECUTE of 4'b1000 -> instruction completes (pc_load=1), FSM in IDLE, imem_req=0; enable=1 resumes FETCH.
- Reset asserted during MEMORY wait -> dmem_req, Memoria, fault = 0 immediately, retired unchanged at 0 after reset.

Source files
------------

// File: rtl/nrisk_ctrl_fsm.sv
// nrisk_ctrl_fsm: multi-cycle control unit for the nRisk core.
// Steps each instruction through FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK
// using valid/ack handshakes with instruction and data memory. Any memory
// wait that runs TIMEOUT cycles without an ack parks the unit in a sticky
// FAULT state. The control-word decode matches the single-cycle decoder;
// only the strobe timing differs.
module nrisk_ctrl_fsm #(
  parameter int OPCODE_W = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                imem_ack,
  input  logic [OPCODE_W-1:0] instr_op,
  input  logic                dmem_ack,
  input  logic                zero_flag,
  output logic                imem_req,
  output logic                ir_write,
  output logic                dmem_req,
  output logic                Memoria,
  output logic                J,
  output logic                Br,
  output logic                pc_load,
  output logic                pc_inc,
  output logic                Tr,
  output logic                Sr,
  output logic                MuxAdd,
  output logic                MuxReg2,
  output logic                MuxSaidaJ,
  output logic                MuxSaidaUla,
  output logic [1:0]          ULA,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  // The wait counter only ever holds 0..TIMEOUT-1; the final value is the
  // last cycle in which an ack is still accepted.
  localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic b7, b6, b5, b4;
  logic tr_dec, mem_op, branch_taken, timeout_hit;

  // Only the top four opcode bits select the control word; the rest are
  // deliberately ignored.
  logic unused_op_bits;
  assign unused_op_bits = ^instr_op;

  // Control-word decode from the registered instruction, MSB first.
  assign {b7, b6, b5, b4} = ir_q;
  assign J           = b7 & ~b6 & ~b5;
  assign Br          = b7 & b6 & b5;
  assign MuxAdd      = ~b7 & ~b6 & ~b5 & ~b4;
  assign MuxReg2     = ((b7 & b6) | (~b7 & ~b6)) & b5;
  assign ULA[1]      = b6 & b5;
  assign ULA[0]      = (~b7 & (b6 ^ b5)) | b7;
  assign MuxSaidaJ   = b7 & b6 & ~b5;
  assign MuxSaidaUla = (~b7 & ~b6) | (b6 & b5);
  assign Sr          = (~b7 & ~b6 & ~b5 & ~b4) | (b7 & ~b6 & b5) | (~b7 & b6 & ~b5);
  assign tr_dec      = (~b7 & ~b6 & ~b5 & b4) | (~b7 & ~b6 & b5) | (b7 & ~b6 & b5)
                     | (~b7 & b6 & ~b5) | (b7 & b6 & b5);
  assign mem_op      = ~b7 & b6 & ~b5;

  assign branch_taken = J | (Br & zero_flag);
  assign timeout_hit  = (wait_q == WAIT_LAST);

  // Strobes are decoded from the current state so that reset removes them
  // in the same instant, without waiting for a clock edge.
  assign imem_req = (state_q == S_FETCH);
  assign ir_write = imem_req & imem_ack;
  assign dmem_req = (state_q == S_MEMORY);
  assign Memoria  = mem_op & dmem_req;
  assign pc_load  = (state_q == S_EXECUTE) & branch_taken;
  assign pc_inc   = (state_q == S_WRITEBACK) & ~taken_q;
  assign Tr       = (state_q == S_WRITEBACK) & tr_dec;
  assign fault    = (state_q == S_FAULT);
  assign retired  = retired_q;

  // Next-state, IR capture, wait counting and retirement.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;
    taken_d   = taken_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr_op[OPCODE_W-1 -: 4];
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        taken_d = branch_taken;
        state_d = mem_op ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        retired_d = retired_q + 1'b1;
        state_d   = enable ? S_FETCH : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_nrisk_ctrl_fsm.sv
// tb_nrisk_ctrl_fsm: directed plus randomized bench for nrisk_ctrl_fsm.
// Expected control words come from per-signal opcode sets; expected strobes
// come from an instruction-level model that knows how many cycles each phase
// lasts.
module tb_nrisk_ctrl_fsm;

  localparam int OPCODE_W = 6;
  localparam int TIMEOUT  = 4;
  localparam int CNT_W    = 4;

  // Bit n set means opcode n drives that signal high.
  localparam logic [15:0] M_J    = 16'h0300;
  localparam logic [15:0] M_BR   = 16'hC000;
  localparam logic [15:0] M_MADD = 16'h0001;
  localparam logic [15:0] M_MR2  = 16'hC00C;
  localparam logic [15:0] M_ULA1 = 16'hC0C0;
  localparam logic [15:0] M_ULA0 = 16'hFF3C;
  localparam logic [15:0] M_MSJ  = 16'h3000;
  localparam logic [15:0] M_MSU  = 16'hC0CF;
  localparam logic [15:0] M_SR   = 16'h0C31;
  localparam logic [15:0] M_TR   = 16'hCC3E;
  localparam logic [15:0] M_MEM  = 16'h0030;

  logic                clock = 1'b0;
  logic                reset, enable, imem_ack, dmem_ack, zero_flag;
  logic [OPCODE_W-1:0] instr_op;
  logic                imem_req, ir_write, dmem_req, Memoria, J, Br;
  logic                pc_load, pc_inc, Tr, Sr, MuxAdd, MuxReg2;
  logic                MuxSaidaJ, MuxSaidaUla, fault;
  logic [1:0]          ULA;
  logic [CNT_W-1:0]    retired;

  int       checks = 0;
  int       errors = 0;
  logic [3:0] exp_ir;
  int       exp_retired;
  bit       flt;

  nrisk_ctrl_fsm #(.OPCODE_W(OPCODE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .imem_ack(imem_ack),
    .instr_op(instr_op), .dmem_ack(dmem_ack), .zero_flag(zero_flag),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
    .Memoria(Memoria), .J(J), .Br(Br), .pc_load(pc_load), .pc_inc(pc_inc),
    .Tr(Tr), .Sr(Sr), .MuxAdd(MuxAdd), .MuxReg2(MuxReg2),
    .MuxSaidaJ(MuxSaidaJ), .MuxSaidaUla(MuxSaidaUla), .ULA(ULA),
    .fault(fault), .retired(retired)
  );

  always #5 clock = ~clock;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OPCODE_W-1:0] rop();
    return OPCODE_W'($urandom);
  endfunction

  // Opcode with fixed decode bits and random ignored low bits.
  function automatic logic [OPCODE_W-1:0] mk_op(input logic [3:0] hi);
    return {hi, (OPCODE_W-4)'($urandom)};
  endfunction

  function automatic logic [8:0] exp_levels(input logic [3:0] op);
    return {M_J[op], M_BR[op], M_MADD[op], M_MR2[op], M_MSJ[op], M_MSU[op],
            M_SR[op], M_ULA1[op], M_ULA0[op]};
  endfunction

  // Strobe vector: {imem_req, ir_write, dmem_req, Memoria, pc_load, pc_inc, Tr, fault}
  task automatic check_out(input string tag, input logic [7:0] exp_s);
    logic [7:0]       obs_s;
    logic [8:0]       obs_l, exp_l;
    logic [CNT_W-1:0] exp_r;
    obs_s = {imem_req, ir_write, dmem_req, Memoria, pc_load, pc_inc, Tr, fault};
    obs_l = {J, Br, MuxAdd, MuxReg2, MuxSaidaJ, MuxSaidaUla, Sr, ULA};
    exp_l = exp_levels(exp_ir);
    exp_r = CNT_W'(exp_retired);
    checks++;
    assert (obs_s === exp_s) else begin
      errors++;
      $error("FAIL %s strobes observed %b expected %b", tag, obs_s, exp_s);
    end
    checks++;
    assert (obs_l === exp_l) else begin
      errors++;
      $error("FAIL %s levels observed %b expected %b", tag, obs_l, exp_l);
    end
    checks++;
    assert (retired === exp_r) else begin
      errors++;
      $error("FAIL %s retired observed %0d expected %0d", tag, retired, exp_r);
    end
  endtask

  task automatic step(input string tag, input logic en, input logic ia, input logic da,
                      input logic zf, input logic [OPCODE_W-1:0] op, input logic [7:0] exp_s);
    @(negedge clock);
    enable    = en;
    imem_ack  = ia;
    dmem_ack  = da;
    zero_flag = zf;
    instr_op  = op;
    #1;
    check_out(tag, exp_s);
  endtask

  task automatic idle(input logic en);
    step("idle", en, rb(), rb(), rb(), rop(), 8'h00);
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) step("fault", rb(), rb(), rb(), rb(), rop(), 8'h01);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset    = 1'b1;
    enable   = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    exp_ir      = 4'd0;
    exp_retired = 0;
    check_out(tag, 8'h00);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One instruction from its first FETCH cycle. fw/dw are the wait cycles
  // before the ack; a value >= TIMEOUT means the ack never comes.
  task automatic run_instr(input logic [OPCODE_W-1:0] op, input logic zf, input int fw,
                           input int dw, input logic en_wb, output bit faulted);
    logic [3:0] op4;
    logic       taken, tr_e, mem_e;
    bit         got;
    op4     = op[OPCODE_W-1 -: 4];
    taken   = M_J[op4] | (M_BR[op4] & zf);
    tr_e    = M_TR[op4];
    mem_e   = M_MEM[op4];
    faulted = 1'b0;
    got     = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      got = (k == fw);
      step("fetch", rb(), got, rb(), rb(), got ? op : rop(), {1'b1, got, 6'b0});
      if (got) break;
    end
    if (!got) begin
      faulted = 1'b1;
      return;
    end
    exp_ir = op4;
    step("decode", rb(), rb(), rb(), rb(), rop(), 8'h00);
    step("execute", rb(), rb(), rb(), zf, rop(), {4'b0, taken, 3'b0});
    if (mem_e) begin
      got = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
        got = (k == dw);
        step("memory", rb(), rb(), got, rb(), rop(), 8'h30);
        if (got) break;
      end
      if (!got) begin
        faulted = 1'b1;
        return;
      end
    end
    step("writeback", en_wb, rb(), rb(), rb(), rop(), {5'b0, ~taken, tr_e, 1'b0});
    exp_retired = (exp_retired + 1) % (1 << CNT_W);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    zero_flag   = 1'b0;
    instr_op    = '0;
    exp_ir      = 4'd0;
    exp_retired = 0;

    @(negedge clock);
    #1;
    check_out("reset", 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Held in IDLE until enable.
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);

    // ALU op with zero-wait fetch, then a branch taken and not taken.
    run_instr(mk_op(4'b0011), rb(), 0, 0, 1'b1, flt);
    run_instr(mk_op(4'b1110), 1'b1, 0, 0, 1'b1, flt);
    run_instr(mk_op(4'b1110), 1'b0, 0, 0, 1'b1, flt);

    // Memory op with a 3-cycle data wait.
    run_instr(mk_op(4'b0100), rb(), 0, 3, 1'b1, flt);

    // Jump completes with enable low, then parks in IDLE and resumes.
    run_instr(mk_op(4'b1000), rb(), 0, 0, 1'b0, flt);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);

    // Acks arriving on the last cycle before the timeout are still accepted.
    run_instr(mk_op(4'b0101), rb(), TIMEOUT - 1, TIMEOUT - 1, 1'b1, flt);

    // Random instruction stream; long enough to wrap the retired counter.
    for (int i = 0; i < 40; i++) begin
      logic en_wb;
      en_wb = ($urandom_range(0, 3) != 0);
      run_instr(rop(), rb(), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1),
                en_wb, flt);
      if (!en_wb) begin
        repeat ($urandom_range(0, 2)) idle(1'b0);
        idle(1'b1);
      end
    end

    // Fetch never acked: sticky fault until reset.
    run_instr(rop(), rb(), TIMEOUT, 0, 1'b1, flt);
    fault_hold(3);
    do_reset("reset_after_ifault");
    idle(1'b0);

    // Data access never acked.
    idle(1'b1);
    run_instr(mk_op(4'b0100), rb(), 0, TIMEOUT, 1'b1, flt);
    fault_hold(3);
    do_reset("reset_after_dfault");
    idle(1'b0);

    // Reset in the middle of a data wait drops the request at once.
    idle(1'b1);
    step("fetch", 1'b1, 1'b1, 1'b0, 1'b0, mk_op(4'b0100), 8'hC0);
    exp_ir = 4'b0100;
    step("decode", 1'b1, 1'b0, 1'b0, 1'b0, rop(), 8'h00);
    step("execute", 1'b1, 1'b0, 1'b0, 1'b0, rop(), 8'h00);
    step("memory", 1'b1, 1'b0, 1'b0, 1'b0, rop(), 8'h30);
    step("memory", 1'b1, 1'b0, 1'b0, 1'b0, rop(), 8'h30);
    do_reset("reset_in_memory");
    idle(1'b0);
    idle(1'b0);

    // Normal operation resumes after reset.
    idle(1'b1);
    run_instr(mk_op(4'b0001), rb(), 1, 0, 1'b0, flt);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
